// File: rtl/button_gesture.sv
// Classifies a debounced button level into short, long, auto-repeat and double presses.
// All outputs are registered and cleared by a synchronous active-low reset.
module button_gesture #(
    parameter int unsigned LONG_COUNTS   = 32'd25_000_000,
    parameter int unsigned GAP_COUNTS    = 32'd12_500_000,
    parameter int unsigned REPEAT_COUNTS = 32'd5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_level,
    output logic short_press,
    output logic long_press,
    output logic repeat_press,
    output logic double_press,
    output logic held
);

    localparam int CNT_W = 26;
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_COUNTS - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_COUNTS - 32'd1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNTS - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRESS1   = 3'd1,
        S_LONG     = 3'd2,
        S_WAIT_GAP = 3'd3,
        S_PRESS2   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_level_q;
    logic             rise_s, fall_s;
    logic             short_d, long_d, repeat_d, double_d, held_d;

    assign rise_s = button_level & ~prev_level_q;
    assign fall_s = ~button_level & prev_level_q;

    // Next-state, counter and pulse decode; edges win over timeouts in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 26'd1;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        double_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 26'd0;
                if (rise_s) begin
                    state_d = S_PRESS1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRESS1: begin
                if (fall_s) begin
                    state_d = S_WAIT_GAP;
                    cnt_d   = 26'd0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = S_LONG;
                    cnt_d   = 26'd0;
                    long_d  = 1'b1;
                end else begin
                    state_d = S_PRESS1;
                end
            end
            S_LONG: begin
                if (fall_s) begin
                    state_d = S_IDLE;
                    cnt_d   = 26'd0;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = 26'd0;
                    repeat_d = 1'b1;
                end else begin
                    state_d = S_LONG;
                end
            end
            S_WAIT_GAP: begin
                if (rise_s) begin
                    state_d = S_PRESS2;
                    cnt_d   = 26'd0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 26'd0;
                    short_d = 1'b1;
                end else begin
                    state_d = S_WAIT_GAP;
                end
            end
            S_PRESS2: begin
                cnt_d = 26'd0;
                if (fall_s) begin
                    state_d  = S_IDLE;
                    double_d = 1'b1;
                end else begin
                    state_d = S_PRESS2;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 26'd0;
            end
        endcase
        held_d = (state_d == S_PRESS1) || (state_d == S_LONG) || (state_d == S_PRESS2);
    end

    // State, counter, edge history and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 26'd0;
            prev_level_q <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_press <= 1'b0;
            double_press <= 1'b0;
            held         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_level_q <= button_level;
            short_press  <= short_d;
            long_press   <= long_d;
            repeat_press <= repeat_d;
            double_press <= double_d;
            held         <= held_d;
        end
    end

endmodule

// File: tb/tb_button_gesture.sv
// Directed bench for button_gesture with LONG=8, GAP=4, REPEAT=3; outputs are
// compared every cycle as {short, long, repeat, double, held}.
module tb_button_gesture;

    logic clk = 1'b0;
    logic rst_n;
    logic button_level;
    logic short_press, long_press, repeat_press, double_press, held;

    int n_checks = 0;
    int n_fail   = 0;

    button_gesture #(
        .LONG_COUNTS  (32'd8),
        .GAP_COUNTS   (32'd4),
        .REPEAT_COUNTS(32'd3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button_level(button_level),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_press(repeat_press),
        .double_press(double_press),
        .held        (held)
    );

    always #5 clk = ~clk;

    // Reset values, then release with the button already down (rise seen at once).
    task automatic test_reset();
        logic [31:0] lvl = 32'h0000_000C;
        logic [4:0]  obs, exp;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            rst_n        = (c >= 3) ? 1'b1 : 1'b0;
            button_level = lvl[c];
            @(posedge clk);
            #1;
            obs = {short_press, long_press, repeat_press, double_press, held};
            exp = {(c == 8), 1'b0, 1'b0, 1'b0, (c == 3)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_short();
        logic [31:0] lvl = 32'h0000_0007;
        logic [4:0]  obs, exp;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            button_level = lvl[c];
            @(posedge clk);
            #1;
            obs = {short_press, long_press, repeat_press, double_press, held};
            exp = {(c == 7), 1'b0, 1'b0, 1'b0, (c <= 2)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL short cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_long_repeat();
        logic [31:0] lvl = 32'h0000_FFFF;
        logic [4:0]  obs, exp;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            button_level = lvl[c];
            @(posedge clk);
            #1;
            obs = {short_press, long_press, repeat_press, double_press, held};
            exp = {1'b0, (c == 8), (c == 11 || c == 14), 1'b0, (c <= 15)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL long_repeat cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_double();
        logic [31:0] lvl = 32'h00FF_FFF3;
        logic [4:0]  obs, exp;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            button_level = lvl[c];
            @(posedge clk);
            #1;
            obs = {short_press, long_press, repeat_press, double_press, held};
            exp = {1'b0, 1'b0, 1'b0, (c == 24), (c <= 1 || (c >= 4 && c <= 23))};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL double cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    // Release on the very cycle the long threshold would fire.
    task automatic test_fall_at_long_edge();
        logic [31:0] lvl = 32'h0000_00FF;
        logic [4:0]  obs, exp;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            button_level = lvl[c];
            @(posedge clk);
            #1;
            obs = {short_press, long_press, repeat_press, double_press, held};
            exp = {(c == 12), 1'b0, 1'b0, 1'b0, (c <= 7)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL fall_at_long_edge cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    // Second press lands on the very cycle the gap timeout would fire.
    task automatic test_rise_at_gap_edge();
        logic [31:0] lvl = 32'h0000_00C3;
        logic [4:0]  obs, exp;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            button_level = lvl[c];
            @(posedge clk);
            #1;
            obs = {short_press, long_press, repeat_press, double_press, held};
            exp = {1'b0, 1'b0, 1'b0, (c == 8), (c <= 1 || c == 6 || c == 7)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rise_at_gap_edge cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    // Reset pulse while in LONG, then an ordinary short press.
    task automatic test_reset_mid_gesture();
        logic [31:0] lvl = 32'h0000_77FF;
        logic [4:0]  obs, exp;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            rst_n        = (c == 10) ? 1'b0 : 1'b1;
            button_level = lvl[c];
            @(posedge clk);
            #1;
            obs = {short_press, long_press, repeat_press, double_press, held};
            exp = {(c == 19), (c == 8), 1'b0, 1'b0, (c <= 9 || (c >= 12 && c <= 14))};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_gesture cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        button_level = 1'b0;
        test_reset();
        test_short();
        test_long_repeat();
        test_double();
        test_fall_at_long_edge();
        test_rise_at_gap_edge();
        test_reset_mid_gesture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
